// File: rtl/seq_approx_div_ctrl.sv
// seq_approx_div_ctrl: sequential 16/8 restoring divider built around a single
// 8-bit subtract/restore row that is reused for all 8 quotient bits, walking
// the quotient index from 7 down to 0. The low bits of the row use
// approximate subtractor cells, and the number of approximate bits grows as
// the bit index falls.
//
// Optional build macro APPROX_CFG_EN: when defined, adds input approx_start
// (sampled on the accepting edge, values above 8 treated as 8) and output
// approx_used (the value in effect for the current/held result). When
// undefined, the APPROX_START parameter applies to every division.
module seq_approx_div_ctrl #(
  parameter int APPROX_START = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        dz,
  output logic        ovf
`ifdef APPROX_CFG_EN
  ,
  input  logic [3:0]  approx_start,
  output logic [3:0]  approx_used
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Parameter clamped into the legal 0..8 range of approximate bits.
  localparam logic [3:0] APX_PARAM = (APPROX_START <= 0) ? 4'd0 :
                                     (APPROX_START >= 8) ? 4'd8 :
                                     4'(APPROX_START);

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [7:0]  y_q;
  logic [8:0]  pr_q;      // partial remainder, bit 8 is the shifted-out MSB
  logic [6:0]  ds_q;      // dividend bits still to be shifted into pr
  logic [2:0]  cnt_q;     // quotient bit index being produced
  logic [7:0]  q_q;
  logic [7:0]  r_q;
  logic        dz_q;
  logic        ovf_q;
  logic [3:0]  apx_q;     // approximation start in effect for this division

  logic [3:0]  apx_d;
  logic [3:0]  mask_d;
  logic        row_qs_d;
  logic [7:0]  row_rout_d;

  // Values above 8 mean "whole row approximate".
  function automatic logic [3:0] clamp_apx(input logic [3:0] a);
    return (a > 4'd8) ? 4'd8 : a;
  endfunction

  // Number of approximate low bits for quotient bit j: max(0, a - j).
  function automatic logic [3:0] mask_width(input logic [3:0] a,
                                            input logic [2:0] j);
    logic [3:0] jj;
    jj = {1'b0, j};
    return (a > jj) ? (a - jj) : 4'd0;
  endfunction

  // One subtract/restore row: ripple-borrow subtractor with the low m cells
  // approximate, then restore when the trial subtraction borrowed and the
  // shifted-out MSB does not cover it. Returns {qs, rout}.
  function automatic logic [8:0] row_eval(input logic [8:0] pr,
                                          input logic [7:0] b,
                                          input logic [3:0] m);
    logic       bin;
    logic       bout;
    logic       qs;
    logic [7:0] diff;
    bin  = 1'b0;
    bout = 1'b0;
    diff = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < m) begin
        bout    = b[i] | (~pr[i] & bin);
        diff[i] = (pr[i] ^ b[i]) | bin;
      end else begin
        bout    = (~pr[i] & bin) | (~pr[i] & b[i]) | (b[i] & bin);
        diff[i] = pr[i] ^ b[i] ^ bin;
      end
      bin = bout;
    end
    qs = ~bin | pr[8];
    return {qs, (qs ? diff : pr[7:0])};
  endfunction

`ifdef APPROX_CFG_EN
  assign apx_d       = clamp_apx(approx_start);
  assign approx_used = apx_q;
`else
  assign apx_d       = APX_PARAM;
`endif

  // Shared row evaluated on the current partial remainder and latched divisor.
  always_comb begin
    mask_d                 = mask_width(apx_q, cnt_q);
    {row_qs_d, row_rout_d} = row_eval(pr_q, y_q, mask_d);
  end

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      pr_q        <= '0;
      ds_q        <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      apx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            y_q        <= y;
            pr_q       <= x[15:7];
            ds_q       <= x[6:0];
            dz_q       <= (y == 8'd0);
            ovf_q      <= (x[15:8] >= y);
            cnt_q      <= 3'd7;
            apx_q      <= apx_d;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          q_q[cnt_q] <= row_qs_d;
          if (cnt_q != 3'd0) begin
            pr_q  <= {row_rout_d, ds_q[6]};
            ds_q  <= {ds_q[5:0], 1'b0};
            cnt_q <= cnt_q - 3'd1;
          end else begin
            r_q     <= row_rout_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Valid is raised one edge after the last row so that q, r and the
          // flags are all settled in their registers before it is seen.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule
